mips_mc_ctrl: RTL and testbench

Multi-cycle MIPS main control FSM that sits directly upstream of the ALU and drives its 3-bit ALUctr input, plus all datapath enables and mux selects. It sequences each instruction through fetch, decode, execute, memory and writeback, and decodes Op/Funct into the ALU operation for each cycle. It consumes the ALU Zero flag to resolve beq.

---
 rtl/mips_pkg.sv | 63 ++++++
 rtl/mips_alu_dec.sv | 28 ++
 rtl/mips_mc_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS control logic: FSM state codes, opcode and
// funct field values, ALU operation codes, and the bundle of control signals
// produced by the multi-cycle controller. The pipelined core reuses this package.
package mips_pkg;

  // Controller states. The 4-bit code is also exported on the State debug port.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  // Opcode field, instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Funct field, instruction[5:0], for R-type
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Datapath control bundle decoded from the current state.
  // pc_write / pc_write_cond are internal; they combine with Zero into PCEn.
  typedef struct packed {
    logic [2:0] alu_ctr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mips_alu_dec.sv
// Combinational R-type funct decoder.
// Ports:
//   funct_i  [5:0] instruction funct field
//   aluctr_o [2:0] ALU operation for the funct (ADD when unsupported)
//   valid_o        1 when the funct is a supported R-type operation
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] aluctr_o,
  output logic       valid_o
);

  // Map funct onto the ALU operation; unknown functs report invalid
  always_comb begin
    aluctr_o = ALU_ADD;
    valid_o  = 1'b1;
    case (funct_i)
      FN_ADD:  aluctr_o = ALU_ADD;
      FN_SUB:  aluctr_o = ALU_SUB;
      FN_AND:  aluctr_o = ALU_AND;
      FN_OR:   aluctr_o = ALU_OR;
      FN_SLT:  aluctr_o = ALU_SLT;
      default: valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main control FSM. Sequences each instruction through
// fetch, decode, execute, memory and writeback and drives the ALU operation,
// datapath enables and mux selects. Memory states stall MEM_WAIT extra cycles.
// Ports:
//   clock, reset (async, active-high)
//   Op, Funct   instruction fields from the IR
//   Zero        ALU zero flag, resolves beq
//   ALUctr, ALUSrcA, ALUSrcB, PCSource, PCEn, IorD, MemRead, MemWrite,
//   IRWrite, RegDst, MemtoReg, RegWrite  datapath controls
//   Illegal     one-cycle pulse in DECODE for unsupported Op/Funct
//   State       current state code (debug)
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 32'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic [2:0] ALUctr,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  ctrl_t      ctrl_s;
  logic [2:0] fn_alu_s;
  logic       fn_valid_s;
  logic       mem_done_s;

  mips_alu_dec u_alu_dec (
    .funct_i  (Funct),
    .aluctr_o (fn_alu_s),
    .valid_o  (fn_valid_s)
  );

  // The current memory access finishes on the cycle the counter reaches MEM_WAIT
  assign mem_done_s = (cnt_q == WAIT_LAST);

  // State and wait-counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and per-state control decode. The counter defaults to 0 so it
  // is already clear whenever a memory state is entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = 3'd0;
    ctrl_s  = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_s.mem_read  = 1'b1;
        ctrl_s.alu_src_b = 2'b01;
        ctrl_s.alu_ctr   = ALU_ADD;
        if (mem_done_s) begin
          ctrl_s.ir_write = 1'b1;
          ctrl_s.pc_write = 1'b1;
          state_d         = S_DECODE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut
        ctrl_s.alu_src_b = 2'b11;
        ctrl_s.alu_ctr   = ALU_ADD;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (fn_valid_s) begin
              state_d = S_RTEXEC;
            end else begin
              ctrl_s.illegal = 1'b1;
              state_d        = S_FETCH;
            end
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_J:    state_d = S_JUMP;
          OP_ADDI: state_d = S_ADDIEX;
          default: begin
            ctrl_s.illegal = 1'b1;
            state_d        = S_FETCH;
          end
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = 2'b10;
        ctrl_s.alu_ctr   = ALU_ADD;
        if (state_q == S_ADDIEX) begin
          state_d = S_ADDIWB;
        end else if (Op == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMRD: begin
        ctrl_s.mem_read = 1'b1;
        ctrl_s.iord     = 1'b1;
        if (mem_done_s) begin
          state_d = S_MEMWB;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_MEMWR: begin
        ctrl_s.mem_write = 1'b1;
        ctrl_s.iord      = 1'b1;
        if (mem_done_s) begin
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_MEMWB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = 1'b1;
        state_d           = S_FETCH;
      end
      S_RTEXEC: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_ctr   = fn_alu_s;
        state_d          = S_RTWB;
      end
      S_RTWB: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.reg_dst   = 1'b1;
        state_d          = S_FETCH;
      end
      S_ADDIWB: begin
        ctrl_s.reg_write = 1'b1;
        state_d          = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_s.alu_src_a     = 1'b1;
        ctrl_s.alu_ctr       = ALU_SUB;
        ctrl_s.pc_write_cond = 1'b1;
        ctrl_s.pc_source     = 2'b01;
        state_d              = S_FETCH;
      end
      S_JUMP: begin
        ctrl_s.pc_write  = 1'b1;
        ctrl_s.pc_source = 2'b10;
        state_d          = S_FETCH;
      end
      default: begin
        // Unused codes recover to FETCH with all controls low
        state_d = S_FETCH;
      end
    endcase
  end

  // Drive the ports; everything reads 0 while reset is held
  always_comb begin
    ALUctr   = 3'b000;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSource = 2'b00;
    PCEn     = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    Illegal  = 1'b0;
    State    = 4'd0;
    if (reset) begin
      State = 4'd0;
    end else begin
      ALUctr   = ctrl_s.alu_ctr;
      ALUSrcA  = ctrl_s.alu_src_a;
      ALUSrcB  = ctrl_s.alu_src_b;
      PCSource = ctrl_s.pc_source;
      PCEn     = ctrl_s.pc_write | (ctrl_s.pc_write_cond & Zero);
      IorD     = ctrl_s.iord;
      MemRead  = ctrl_s.mem_read;
      MemWrite = ctrl_s.mem_write;
      IRWrite  = ctrl_s.ir_write;
      RegDst   = ctrl_s.reg_dst;
      MemtoReg = ctrl_s.mem_to_reg;
      RegWrite = ctrl_s.reg_write;
      Illegal  = ctrl_s.illegal;
      State    = state_q;
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl. Three instances run with MEM_WAIT
// 0, 2 and 3; each instruction is expanded by a reference model into the
// per-cycle control vector the controller must present.
module tb_mips_mc_ctrl;

  typedef logic [20:0] obs_t;

  logic       clock = 1'b0;
  logic       reset_a    [3];
  logic [5:0] op_a       [3];
  logic [5:0] funct_a    [3];
  logic       zero_a     [3];
  logic [2:0] aluctr_w   [3];
  logic       alusrca_w  [3];
  logic [1:0] alusrcb_w  [3];
  logic [1:0] pcsource_w [3];
  logic       pcen_w     [3];
  logic       iord_w     [3];
  logic       memread_w  [3];
  logic       memwrite_w [3];
  logic       irwrite_w  [3];
  logic       regdst_w   [3];
  logic       memtoreg_w [3];
  logic       regwrite_w [3];
  logic       illegal_w  [3];
  logic [3:0] state_w    [3];

  int n_checks = 0;
  int n_fail   = 0;
  int memwrite_cycles;
  obs_t exp_q[$];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned MW = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    mips_mc_ctrl #(.MEM_WAIT(MW)) u_dut (
      .clock    (clock),
      .reset    (reset_a[g]),
      .Op       (op_a[g]),
      .Funct    (funct_a[g]),
      .Zero     (zero_a[g]),
      .ALUctr   (aluctr_w[g]),
      .ALUSrcA  (alusrca_w[g]),
      .ALUSrcB  (alusrcb_w[g]),
      .PCSource (pcsource_w[g]),
      .PCEn     (pcen_w[g]),
      .IorD     (iord_w[g]),
      .MemRead  (memread_w[g]),
      .MemWrite (memwrite_w[g]),
      .IRWrite  (irwrite_w[g]),
      .RegDst   (regdst_w[g]),
      .MemtoReg (memtoreg_w[g]),
      .RegWrite (regwrite_w[g]),
      .Illegal  (illegal_w[g]),
      .State    (state_w[g])
    );
  end

  function automatic int mw_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  function automatic obs_t observe(input int k);
    return {state_w[k], aluctr_w[k], alusrca_w[k], alusrcb_w[k], pcsource_w[k],
            pcen_w[k], iord_w[k], memread_w[k], memwrite_w[k], irwrite_w[k],
            regdst_w[k], memtoreg_w[k], regwrite_w[k], illegal_w[k]};
  endfunction

  function automatic obs_t mk(input logic [3:0] st, input logic [2:0] alu,
                              input logic sa, input logic [1:0] sb, input logic [1:0] pcs,
                              input logic pcen, input logic iord, input logic mrd,
                              input logic mwr, input logic irw, input logic rdst,
                              input logic m2r, input logic rw, input logic ill);
    return {st, alu, sa, sb, pcs, pcen, iord, mrd, mwr, irw, rdst, m2r, rw, ill};
  endfunction

  // Funct -> ALU op table of the instruction set
  function automatic logic [3:0] ref_funct(input logic [5:0] f);
    case (f)
      6'b100000: return {1'b1, 3'b010};
      6'b100010: return {1'b1, 3'b110};
      6'b100100: return {1'b1, 3'b000};
      6'b100101: return {1'b1, 3'b001};
      6'b101010: return {1'b1, 3'b111};
      default:   return 4'b0000;
    endcase
  endfunction

  // Expand one instruction into its expected cycle-by-cycle control vectors
  task automatic build_expect(input int mw, input logic [5:0] op, input logic [5:0] fn,
                              input logic zero);
    logic [3:0] fd;
    logic       legal;
    exp_q.delete();
    fd = ref_funct(fn);
    for (int i = 0; i <= mw; i++) begin
      exp_q.push_back(mk(4'd0, 3'b010, 1'b0, 2'b01, 2'b00, (i == mw), 1'b0, 1'b1, 1'b0,
                         (i == mw), 1'b0, 1'b0, 1'b0, 1'b0));
    end
    legal = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000100) ||
            (op == 6'b000010) || (op == 6'b001000) || ((op == 6'b000000) && fd[3]);
    exp_q.push_back(mk(4'd1, 3'b010, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                       1'b0, 1'b0, 1'b0, 1'b0, !legal));
    if (!legal) return;
    if (op == 6'b100011 || op == 6'b101011) begin
      exp_q.push_back(mk(4'd2, 3'b010, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i <= mw; i++) begin
        if (op == 6'b100011)
          exp_q.push_back(mk(4'd3, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        else
          exp_q.push_back(mk(4'd5, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      if (op == 6'b100011)
        exp_q.push_back(mk(4'd4, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                           1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    end else if (op == 6'b000000) begin
      exp_q.push_back(mk(4'd6, fd[2:0], 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(4'd7, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    end else if (op == 6'b000100) begin
      exp_q.push_back(mk(4'd8, 3'b110, 1'b1, 2'b00, 2'b01, zero, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end else if (op == 6'b000010) begin
      exp_q.push_back(mk(4'd9, 3'b000, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end else begin
      exp_q.push_back(mk(4'd10, 3'b010, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(4'd11, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end
  endtask

  // Run one instruction on instance k (starting at a falling edge in FETCH),
  // checking up to 'limit' cycles (all cycles when limit < 0)
  task automatic run_instr(input string name, input int k, input logic [5:0] op,
                           input logic [5:0] fn, input logic zero, input int limit);
    obs_t got;
    int   n;
    build_expect(mw_of(k), op, fn, zero);
    n = (limit < 0 || limit > exp_q.size()) ? exp_q.size() : limit;
    memwrite_cycles = 0;
    for (int i = 0; i < n; i++) begin
      op_a[k] = op; funct_a[k] = fn; zero_a[k] = zero;
      #1;
      got = observe(k);
      if (memwrite_w[k] === 1'b1) memwrite_cycles++;
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i, got, exp_q[i]);
      end
      @(negedge clock);
    end
  endtask

  // Pulse reset on one instance so it starts a fresh FETCH on this falling edge
  task automatic sync_start(input int k);
    reset_a[k] = 1'b1;
    @(negedge clock);
    reset_a[k] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    @(negedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (observe(k) !== 21'd0) begin
        n_fail++;
        $display("FAIL reset_outputs inst %0d: got %h expected %h", k, observe(k), 21'd0);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_rtype();
    sync_start(0);
    run_instr("rtype_slt", 0, 6'b000000, 6'b101010, 1'b0, -1);
    run_instr("rtype_sub", 0, 6'b000000, 6'b100010, 1'b1, -1);
    run_instr("rtype_or",  0, 6'b000000, 6'b100101, 1'b0, -1);
  endtask

  task automatic test_lw();
    run_instr("lw", 0, 6'b100011, 6'b000000, 1'b0, -1);
    run_instr("addi", 0, 6'b001000, 6'b010101, 1'b0, -1);
    run_instr("jump", 0, 6'b000010, 6'b000000, 1'b0, -1);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", 0, 6'b000100, 6'b000000, 1'b1, -1);
    run_instr("beq_not_taken", 0, 6'b000100, 6'b000000, 1'b0, -1);
  endtask

  task automatic test_illegal();
    run_instr("illegal_op", 0, 6'b111111, 6'b000000, 1'b1, -1);
    run_instr("illegal_funct", 0, 6'b000000, 6'b000000, 1'b1, -1);
    run_instr("after_illegal", 0, 6'b101011, 6'b000000, 1'b0, -1);
  endtask

  task automatic test_sw_wait();
    sync_start(2);
    run_instr("sw_wait3", 2, 6'b101011, 6'b000000, 1'b0, -1);
    n_checks++;
    if (memwrite_cycles !== 4) begin
      n_fail++;
      $display("FAIL sw_memwrite_len: got %0d cycles expected 4", memwrite_cycles);
    end
    run_instr("lw_wait3", 2, 6'b100011, 6'b000000, 1'b0, -1);
  endtask

  task automatic test_reset_mid_memrd();
    sync_start(1);
    // FETCH x3, DECODE, MEMADR, first MEMRD cycle; now in the second MEMRD cycle
    run_instr("lw_before_reset", 1, 6'b100011, 6'b000000, 1'b0, 6);
    reset_a[1] = 1'b1;
    #1;
    n_checks++;
    if (observe(1) !== 21'd0) begin
      n_fail++;
      $display("FAIL async_reset_memrd: got %h expected %h", observe(1), 21'd0);
    end
    @(negedge clock);
    n_checks++;
    if (observe(1) !== 21'd0) begin
      n_fail++;
      $display("FAIL held_reset: got %h expected %h", observe(1), 21'd0);
    end
    reset_a[1] = 1'b0;
    run_instr("lw_after_reset", 1, 6'b100011, 6'b000000, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [6];
    logic [5:0] fns [5];
    logic [5:0] op, fn;
    int r;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int k = 0; k < 3; k++) begin
      sync_start(k);
      for (int n = 0; n < 25; n++) begin
        r  = $urandom_range(0, 7);
        op = (r < 6) ? ops[r] : 6'($urandom);
        fn = ($urandom_range(0, 3) != 0) ? fns[$urandom_range(0, 4)] : 6'($urandom);
        run_instr("random", k, op, fn, 1'($urandom), -1);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      reset_a[k] = 1'b1;
      op_a[k]    = 6'd0;
      funct_a[k] = 6'd0;
      zero_a[k]  = 1'b0;
    end
    test_reset();
    test_rtype();
    test_lw();
    test_beq();
    test_illegal();
    test_sw_wait();
    test_reset_mid_memrd();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
